hex_keypad_operand_entry: RTL

HEX_KEYPAD_OPERAND_ENTRY -- requirements
Module: hex_keypad_operand_entry

---
 rtl/hex_keypad_operand_entry_pkg.sv | 11 +
 rtl/hex_keypad_operand_entry_if.sv | 8 +
 rtl/keypad_scanner.sv | 121 ++++++++++++
 rtl/hex_keypad_operand_entry.sv | 82 ++++++++
 4 files changed

// File: rtl/hex_keypad_operand_entry_pkg.sv
// Shared types and keypad geometry for the hex keypad operand entry block.
package hex_keypad_operand_entry_pkg;

    typedef enum logic [2:0] {A_HI, A_LO, B_HI, B_LO, DONE} entry_state_e;

    localparam int KEYPAD_ROWS = 4;
    localparam int KEYPAD_COLS = 4;
    localparam int ROW_W       = $clog2(KEYPAD_ROWS);
    localparam int COL_W       = $clog2(KEYPAD_COLS);

endpackage

// File: rtl/hex_keypad_operand_entry_if.sv
// Accepted-key event channel from the keypad scanner to the operand entry logic.
interface hex_keypad_operand_entry_if;
    logic       key_strobe;
    logic [3:0] key_code;

    modport master (output key_strobe, output key_code);
    modport slave  (input  key_strobe, input  key_code);
endinterface

// File: rtl/keypad_scanner.sv
// Row-scanning 4x4 keypad reader: column synchronizer, per-scan priority
// encode, whole-scan debounce and one strobe per accepted press.
module keypad_scanner
    import hex_keypad_operand_entry_pkg::*;
#(
    parameter int SCAN_DIV       = 1000,
    parameter int DEBOUNCE_SCANS = 4
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [KEYPAD_COLS-1:0] col_n,
    output logic [KEYPAD_ROWS-1:0] row_n,
    hex_keypad_operand_entry_if.master kif
);
    localparam int CW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam int DW = (DEBOUNCE_SCANS > 1) ? $clog2(DEBOUNCE_SCANS) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(SCAN_DIV - 1);
    localparam logic [DW-1:0] STAB_MAX = DW'(DEBOUNCE_SCANS - 1);

    logic [KEYPAD_COLS-1:0] col_s1_q, col_s2_q;
    logic [CW-1:0]          cnt_q, cnt_d;
    logic [ROW_W-1:0]       row_q, row_d;
    logic                   found_q, found_d;
    logic [3:0]             found_code_q, found_code_d;
    logic                   prev_pressed_q, prev_pressed_d;
    logic [3:0]             prev_code_q, prev_code_d;
    logic [DW-1:0]          stab_q, stab_d;
    logic                   reported_q, reported_d;
    logic                   key_strobe_q, key_strobe_d;
    logic [3:0]             key_code_q, key_code_d;
    logic [COL_W-1:0]       col_idx;
    logic                   scan_pressed;
    logic [3:0]             scan_code;

    always_comb begin
        col_idx = '0;
        for (int c = KEYPAD_COLS - 1; c >= 0; c--)
            if (!col_s2_q[c]) col_idx = COL_W'(c);

        cnt_d          = cnt_q + CW'(1);
        row_d          = row_q;
        found_d        = found_q;
        found_code_d   = found_code_q;
        prev_pressed_d = prev_pressed_q;
        prev_code_d    = prev_code_q;
        stab_d         = stab_q;
        reported_d     = reported_q;
        key_strobe_d   = 1'b0;
        key_code_d     = key_code_q;

        // Rows are visited in ascending order, so the first hit in a scan wins.
        scan_pressed = found_q;
        scan_code    = found_code_q;
        if (!found_q && !(&col_s2_q)) begin
            scan_pressed = 1'b1;
            scan_code    = {row_q, col_idx};
        end

        if (cnt_q == CNT_LAST) begin
            cnt_d        = '0;
            row_d        = row_q + ROW_W'(1);
            found_d      = scan_pressed;
            found_code_d = scan_code;
            if (row_q == ROW_W'(KEYPAD_ROWS - 1)) begin
                found_d        = 1'b0;
                found_code_d   = '0;
                prev_pressed_d = scan_pressed;
                prev_code_d    = scan_pressed ? scan_code : 4'h0;
                if (prev_pressed_d == prev_pressed_q && prev_code_d == prev_code_q)
                    stab_d = (stab_q == STAB_MAX) ? stab_q : stab_q + DW'(1);
                else
                    stab_d = '0;
                // reported_q blocks auto-repeat until a stable release is seen.
                if (stab_d == STAB_MAX) begin
                    if (scan_pressed && !reported_q) begin
                        key_strobe_d = 1'b1;
                        key_code_d   = scan_code;
                        reported_d   = 1'b1;
                    end else if (!scan_pressed) begin
                        reported_d = 1'b0;
                    end
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            col_s1_q       <= '1;
            col_s2_q       <= '1;
            cnt_q          <= '0;
            row_q          <= '0;
            found_q        <= 1'b0;
            found_code_q   <= '0;
            prev_pressed_q <= 1'b0;
            prev_code_q    <= '0;
            stab_q         <= '0;
            reported_q     <= 1'b0;
            key_strobe_q   <= 1'b0;
            key_code_q     <= '0;
        end else begin
            col_s1_q       <= col_n;
            col_s2_q       <= col_s1_q;
            cnt_q          <= cnt_d;
            row_q          <= row_d;
            found_q        <= found_d;
            found_code_q   <= found_code_d;
            prev_pressed_q <= prev_pressed_d;
            prev_code_q    <= prev_code_d;
            stab_q         <= stab_d;
            reported_q     <= reported_d;
            key_strobe_q   <= key_strobe_d;
            key_code_q     <= key_code_d;
        end
    end

    assign row_n          = ~(KEYPAD_ROWS'(1) << row_q);
    assign kif.key_strobe = key_strobe_q;
    assign kif.key_code   = key_code_q;

endmodule

// File: rtl/hex_keypad_operand_entry.sv
// Hex keypad operand entry: collects four accepted key nibbles into operands
// A and B (high nibble first) and flags when both are complete.
module hex_keypad_operand_entry
    import hex_keypad_operand_entry_pkg::*;
#(
    parameter int SCAN_DIV       = 1000,
    parameter int DEBOUNCE_SCANS = 4
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [KEYPAD_COLS-1:0] col_n,
    output logic [KEYPAD_ROWS-1:0] row_n,
    input  logic                   clear,
    output logic [7:0]             a,
    output logic [7:0]             b,
    output logic                   operands_valid,
    output logic                   key_strobe,
    output logic [3:0]             key_code
);
    hex_keypad_operand_entry_if kif ();

    keypad_scanner #(
        .SCAN_DIV       (SCAN_DIV),
        .DEBOUNCE_SCANS (DEBOUNCE_SCANS)
    ) u_scan (
        .clk   (clk),
        .rst   (rst),
        .col_n (col_n),
        .row_n (row_n),
        .kif   (kif)
    );

    entry_state_e state_q, state_d;
    logic [7:0]   a_q, a_d, b_q, b_d;
    logic         valid_q;

    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        // clear beats a coincident strobe; the key is dropped.
        if (clear) begin
            state_d = A_HI;
            a_d     = '0;
            b_d     = '0;
        end else if (kif.key_strobe) begin
            case (state_q)
                A_HI: begin a_d[7:4] = kif.key_code; state_d = A_LO; end
                A_LO: begin a_d[3:0] = kif.key_code; state_d = B_HI; end
                B_HI: begin b_d[7:4] = kif.key_code; state_d = B_LO; end
                B_LO: begin b_d[3:0] = kif.key_code; state_d = DONE; end
                DONE: begin
                    a_d     = {kif.key_code, 4'h0};
                    b_d     = '0;
                    state_d = A_LO;
                end
                default: state_d = A_HI;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= A_HI;
            a_q     <= '0;
            b_q     <= '0;
            valid_q <= 1'b0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            valid_q <= (state_d == DONE);
        end
    end

    assign a              = a_q;
    assign b              = b_q;
    assign operands_valid = valid_q;
    assign key_strobe     = kif.key_strobe;
    assign key_code       = kif.key_code;

endmodule
